cg_stage_sequencer: RTL and testbench

Multi-stage firing sequencer for the coilgun. It holds a per-stage configuration table (delay, limit, mode flags) and fires a chain of `cg_core` instances in order. For each stage it presents that stage's configuration on a shared bus, asserts the stage trigger, and advances when the stage reports pulse completion. It sits between the host/config interface and the bank of `cg_core` instances, and provides timeout, abort and sticky-fault handling.

---
 rtl/cg_pkg.sv | 27 ++
 rtl/cg_stage_cfg.sv | 53 +++++
 rtl/cg_stage_sequencer.sv | 140 ++++++++++++++
 tb/tb_cg_stage_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cg_pkg.sv
// Shared types and constants for the coilgun stage sequencer: FSM states,
// config field selects and flag bit positions.
package cg_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARM   = 3'd2,
        S_NEXT  = 3'd3,
        S_FAULT = 3'd4
    } cg_seq_state_t;

    localparam logic [1:0] CFG_DLY = 2'd0;
    localparam logic [1:0] CFG_LMT = 2'd1;
    localparam logic [1:0] CFG_FLG = 2'd2;

    localparam int FLG_DDS = 0;
    localparam int FLG_LDS = 1;
    localparam int FLG_LEN = 2;
    localparam int FLG_EN  = 3;

    // True when the state belongs to an active firing sequence.
    function automatic logic seq_active(cg_seq_state_t s);
        return (s == S_LOAD) || (s == S_ARM) || (s == S_NEXT);
    endfunction

endpackage

// File: rtl/cg_stage_cfg.sv
// Per-stage configuration bank (delay, limit, flags). Writes are dropped
// while a sequence is running; reads are combinational by stage index.
module cg_stage_cfg
    import cg_pkg::*;
#(
    parameter int N_STAGES = 4,
    parameter int W        = 24,
    parameter int SW       = $clog2(N_STAGES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          busy,
    input  logic [SW-1:0] waddr,
    input  logic [1:0]    sel,
    input  logic [W-1:0]  wdata,
    input  logic [SW-1:0] raddr,
    output logic [W-1:0]  rdly,
    output logic [W-1:0]  rlmt,
    output logic [3:0]    rflg
);

    logic [N_STAGES-1:0][W-1:0] dly_q;
    logic [N_STAGES-1:0][W-1:0] lmt_q;
    logic [N_STAGES-1:0][3:0]   flg_q;
    logic                       wr_ok;

    assign wr_ok = we && !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q <= '0;
            lmt_q <= '0;
            flg_q <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (waddr == SW'(i)) begin
                    case (sel)
                        CFG_DLY: dly_q[i] <= wdata;
                        CFG_LMT: lmt_q[i] <= wdata;
                        CFG_FLG: flg_q[i] <= wdata[3:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign rdly = dly_q[raddr];
    assign rlmt = lmt_q[raddr];
    assign rflg = flg_q[raddr];

endmodule

// File: rtl/cg_stage_sequencer.sv
// Multi-stage coilgun firing sequencer: walks the stage table, presents each
// stage's config, triggers its core and advances on done, with timeout/abort.
module cg_stage_sequencer
    import cg_pkg::*;
#(
    parameter int            N_STAGES = 4,
    parameter int            W        = 24,
    parameter logic [W-1:0]  TMO      = 24'd1_000_000,
    localparam int           SW       = $clog2(N_STAGES)
) (
    input  logic                clk,
    input  logic                I_RST,
    input  logic                I_CFG_WE,
    input  logic [SW-1:0]       I_CFG_ADDR,
    input  logic [1:0]          I_CFG_SEL,
    input  logic [W-1:0]        I_CFG_DATA,
    input  logic                I_FIRE,
    input  logic                I_ABORT,
    input  logic                I_CLR,
    input  logic [N_STAGES-1:0] I_DONE,
    output logic [N_STAGES-1:0] O_TRIG,
    output logic [W-1:0]        O_DLY,
    output logic [W-1:0]        O_LMT,
    output logic [2:0]          O_FLG,
    output logic                O_OE,
    output logic [SW-1:0]       O_STAGE,
    output logic                O_BUSY,
    output logic                O_FAULT
);

    cg_seq_state_t       state, nstate;
    logic [SW-1:0]       stage, nstage;
    logic [W-1:0]        tcnt;
    logic                en_q;
    logic [W-1:0]        c_dly, c_lmt;
    logic [3:0]          c_flg;
    logic [N_STAGES-1:0] trig_d;
    logic                busy_d;
    logic                last_stage;

    cg_stage_cfg #(
        .N_STAGES (N_STAGES),
        .W        (W),
        .SW       (SW)
    ) u_cfg (
        .clk   (clk),
        .rst   (I_RST),
        .we    (I_CFG_WE),
        .busy  (O_BUSY),
        .waddr (I_CFG_ADDR),
        .sel   (I_CFG_SEL),
        .wdata (I_CFG_DATA),
        .raddr (nstage),
        .rdly  (c_dly),
        .rlmt  (c_lmt),
        .rflg  (c_flg)
    );

    assign last_stage = (stage == SW'(N_STAGES - 1));

    // Abort outranks done, which outranks the timeout.
    always_comb begin
        nstate = state;
        nstage = stage;
        case (state)
            S_IDLE: begin
                if (I_FIRE) begin
                    nstate = S_LOAD;
                    nstage = '0;
                end
            end
            S_LOAD: begin
                if (I_ABORT)   nstate = S_IDLE;
                else if (en_q) nstate = S_ARM;
                else           nstate = S_NEXT;
            end
            S_ARM: begin
                if (I_ABORT)                 nstate = S_IDLE;
                else if (I_DONE[stage])      nstate = S_NEXT;
                else if (tcnt == TMO - W'(1)) nstate = S_FAULT;
            end
            S_NEXT: begin
                if (I_ABORT || last_stage) begin
                    nstate = S_IDLE;
                end else begin
                    nstate = S_LOAD;
                    nstage = stage + SW'(1);
                end
            end
            S_FAULT: begin
                if (I_CLR) nstate = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    always_comb begin
        trig_d = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            trig_d[i] = (nstate == S_ARM) && (nstage == SW'(i));
        end
        busy_d = seq_active(nstate);
    end

    // Outputs are registered from next-state so nothing combinational
    // reaches the cores; the reset also drops O_TRIG asynchronously.
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            state   <= S_IDLE;
            stage   <= '0;
            tcnt    <= '0;
            en_q    <= 1'b0;
            O_TRIG  <= '0;
            O_DLY   <= '0;
            O_LMT   <= '0;
            O_FLG   <= '0;
            O_OE    <= 1'b0;
            O_BUSY  <= 1'b0;
            O_FAULT <= 1'b0;
        end else begin
            state   <= nstate;
            stage   <= nstage;
            O_TRIG  <= trig_d;
            O_OE    <= busy_d;
            O_BUSY  <= busy_d;
            O_FAULT <= (nstate == S_FAULT);
            if (state == S_ARM) tcnt <= tcnt + W'(1);
            else                tcnt <= '0;
            if (nstate == S_LOAD) begin
                O_DLY <= c_dly;
                O_LMT <= c_lmt;
                O_FLG <= {c_flg[FLG_LEN], c_flg[FLG_LDS], c_flg[FLG_DDS]};
                en_q  <= c_flg[FLG_EN];
            end
        end
    end

    assign O_STAGE = stage;

endmodule

// File: tb/tb_cg_stage_sequencer.sv
// Scoreboard bench for cg_stage_sequencer: directed sequences push expected
// events; a negedge monitor pops and compares as the DUT produces them.
module tb_cg_stage_sequencer;

    localparam int N = 4;
    localparam int W = 24;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          I_RST;
    logic          I_CFG_WE = 1'b0;
    logic [SW-1:0] I_CFG_ADDR = '0;
    logic [1:0]    I_CFG_SEL = '0;
    logic [W-1:0]  I_CFG_DATA = '0;
    logic          I_FIRE = 1'b0;
    logic          I_ABORT = 1'b0;
    logic          I_CLR = 1'b0;
    logic [N-1:0]  I_DONE = '0;
    logic [N-1:0]  O_TRIG;
    logic [W-1:0]  O_DLY, O_LMT;
    logic [2:0]    O_FLG;
    logic          O_OE;
    logic [SW-1:0] O_STAGE;
    logic          O_BUSY, O_FAULT;

    cg_stage_sequencer #(.N_STAGES(N), .W(W), .TMO(24'd100)) dut (
        .clk(clk), .I_RST(I_RST), .I_CFG_WE(I_CFG_WE), .I_CFG_ADDR(I_CFG_ADDR),
        .I_CFG_SEL(I_CFG_SEL), .I_CFG_DATA(I_CFG_DATA), .I_FIRE(I_FIRE),
        .I_ABORT(I_ABORT), .I_CLR(I_CLR), .I_DONE(I_DONE), .O_TRIG(O_TRIG),
        .O_DLY(O_DLY), .O_LMT(O_LMT), .O_FLG(O_FLG), .O_OE(O_OE),
        .O_STAGE(O_STAGE), .O_BUSY(O_BUSY), .O_FAULT(O_FAULT)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef enum int {EV_START, EV_TRIG, EV_IDLE, EV_FAULT, EV_CLR} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        int            cyc;
        logic [N-1:0]  trig;
        logic          oe;
        logic [SW-1:0] stg;
        logic [W-1:0]  dly;
        logic [W-1:0]  lmt;
        logic [2:0]    flg;
    } ev_t;
    ev_t expq[$];

    function automatic void exp_ev(ev_kind_t k, int c);
        ev_t e;
        e.kind = k; e.cyc = c; e.trig = '0; e.oe = (k == EV_START);
        e.stg = '0; e.dly = '0; e.lmt = '0; e.flg = '0;
        expq.push_back(e);
    endfunction

    function automatic void exp_trig(int c, int s, int d, int l, int f);
        ev_t e;
        e.kind = EV_TRIG; e.cyc = c; e.trig = N'(1 << s); e.oe = 1'b1;
        e.stg = SW'(s); e.dly = W'(d); e.lmt = W'(l); e.flg = 3'(f);
        expq.push_back(e);
    endfunction

    task automatic got(ev_kind_t k, logic [N-1:0] prev);
        ev_t e;
        bit  ok;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: cyc=%0d trig=%b busy=%b fault=%b",
                     k.name(), cyc, O_TRIG, O_BUSY, O_FAULT);
            return;
        end
        e  = expq.pop_front();
        ok = (e.kind == k) && (e.cyc == cyc) && (O_TRIG === e.trig) && (O_OE === e.oe);
        if (k == EV_TRIG)
            ok = ok && (prev == '0) && (O_STAGE === e.stg) && (O_DLY === e.dly)
                    && (O_LMT === e.lmt) && (O_FLG === e.flg);
        if (!ok) begin
            errors++;
            $display("FAIL ev_%s: got cyc=%0d trig=%b oe=%b stg=%0d dly=%0d lmt=%0d flg=%b prev=%b; expected %s cyc=%0d trig=%b oe=%b stg=%0d dly=%0d lmt=%0d flg=%b prev=0",
                     k.name(), cyc, O_TRIG, O_OE, O_STAGE, O_DLY, O_LMT, O_FLG, prev,
                     e.kind.name(), e.cyc, e.trig, e.oe, e.stg, e.dly, e.lmt, e.flg);
        end
    endtask

    // Monitor: turns output transitions into events for the scoreboard.
    logic [N-1:0] ptrig = '0;
    logic         pbusy = 1'b0, pfault = 1'b0, mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (O_FAULT && !pfault)      got(EV_FAULT, ptrig);
            else if (!O_FAULT && pfault) got(EV_CLR, ptrig);
            else if (pbusy && !O_BUSY)   got(EV_IDLE, ptrig);
            if (!pbusy && O_BUSY)        got(EV_START, ptrig);
            if (O_TRIG != '0 && O_TRIG != ptrig) got(EV_TRIG, ptrig);
        end
        ptrig  <= O_TRIG;
        pbusy  <= O_BUSY;
        pfault <= O_FAULT;
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after edge e-1, so inputs set next are sampled at edge e.
    task automatic wait_to(int e);
        if (cyc > e - 1) begin
            errors++;
            $display("FAIL schedule: at cyc %0d, edge %0d already passed", cyc, e);
        end
        while (cyc < e - 1) tick();
    endtask

    task automatic pulse_at(int e, logic [N-1:0] done, logic fire, logic abort, logic clr);
        wait_to(e);
        I_DONE = done; I_FIRE = fire; I_ABORT = abort; I_CLR = clr;
        tick();
        I_DONE = '0; I_FIRE = 1'b0; I_ABORT = 1'b0; I_CLR = 1'b0;
    endtask

    task automatic wr_at(int e, int a, int sel, int d);
        wait_to(e);
        I_CFG_WE = 1'b1; I_CFG_ADDR = SW'(a); I_CFG_SEL = 2'(sel); I_CFG_DATA = W'(d);
        tick();
        I_CFG_WE = 1'b0;
    endtask

    task automatic wr(int a, int sel, int d);
        wr_at(cyc + 1, a, sel, d);
    endtask

    int t, a, k, f, c, b;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        I_RST = 1'b0;
        #2 I_RST = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_trig", 64'(O_TRIG), 0);
        chk("rst_dly", 64'(O_DLY), 0);
        chk("rst_lmt", 64'(O_LMT), 0);
        chk("rst_flg_oe_stage", 64'({O_FLG, O_OE, O_STAGE}), 0);
        chk("rst_busy_fault", 64'({O_BUSY, O_FAULT}), 0);
        I_RST = 1'b0;
        tick();
        mon_en = 1'b1;

        // Basic sequence, stray done, busy-gated write
        for (int i = 0; i < N; i++) begin
            wr(i, 0, 10 * (i + 1));
            wr(i, 1, 200);
            wr(i, 2, 8 | i);
        end
        t = cyc + 3;
        exp_ev(EV_START, t);
        pulse_at(t, '0, 1'b1, 1'b0, 1'b0);
        a = t + 1;
        for (int i = 0; i < N; i++) begin
            exp_trig(a, i, 10 * (i + 1), 200, i);
            if (i == 0) pulse_at(a + 10, 4'b1000, 1'b0, 1'b0, 1'b0);
            if (i == 1) wr_at(a + 10, 3, 0, 999);
            k = a + 50;
            pulse_at(k, N'(1 << i), 1'b0, 1'b0, 1'b0);
            a = k + 2;
        end
        exp_ev(EV_IDLE, k + 1);

        // Skip disabled stage 1; reserved-field write must not land anywhere
        wait_to(k + 5);
        wr(1, 2, 4'b0001);
        wr(0, 3, 77);
        t = cyc + 3;
        exp_ev(EV_START, t);
        pulse_at(t, '0, 1'b1, 1'b0, 1'b0);
        a = t + 1;
        exp_trig(a, 0, 10, 200, 0);
        k = a + 20; pulse_at(k, 4'b0001, 1'b0, 1'b0, 1'b0);
        a = k + 4;
        exp_trig(a, 2, 30, 200, 2);
        k = a + 20; pulse_at(k, 4'b0100, 1'b0, 1'b0, 1'b0);
        a = k + 2;
        exp_trig(a, 3, 40, 200, 3);
        k = a + 20;
        exp_ev(EV_IDLE, k + 1);
        pulse_at(k, 4'b1000, 1'b0, 1'b0, 1'b0);

        // Timeout on stage 2, fire ignored in FAULT, clear
        wait_to(k + 5);
        wr(1, 2, 4'b1001);
        t = cyc + 3;
        exp_ev(EV_START, t);
        pulse_at(t, '0, 1'b1, 1'b0, 1'b0);
        a = t + 1;
        exp_trig(a, 0, 10, 200, 0);
        k = a + 5; pulse_at(k, 4'b0001, 1'b0, 1'b0, 1'b0);
        a = k + 2;
        exp_trig(a, 1, 20, 200, 1);
        k = a + 5; pulse_at(k, 4'b0010, 1'b0, 1'b0, 1'b0);
        a = k + 2;
        exp_trig(a, 2, 30, 200, 2);
        f = a + 100;
        exp_ev(EV_FAULT, f);
        pulse_at(f + 3, '0, 1'b1, 1'b0, 1'b0);
        c = f + 8;
        exp_ev(EV_CLR, c);
        pulse_at(c, '0, 1'b0, 1'b0, 1'b1);

        // Abort in stage 1 ARM, then abort together with done[1]
        for (int r = 0; r < 2; r++) begin
            t = cyc + 4;
            exp_ev(EV_START, t);
            pulse_at(t, '0, 1'b1, 1'b0, 1'b0);
            a = t + 1;
            exp_trig(a, 0, 10, 200, 0);
            k = a + 5; pulse_at(k, 4'b0001, 1'b0, 1'b0, 1'b0);
            a = k + 2;
            exp_trig(a, 1, 20, 200, 1);
            b = a + 3;
            exp_ev(EV_IDLE, b);
            pulse_at(b, (r == 1) ? 4'b0010 : 4'b0000, 1'b0, 1'b1, 1'b0);
        end

        // Done on the very cycle the timeout would fire: advance, no fault
        t = cyc + 4;
        exp_ev(EV_START, t);
        pulse_at(t, '0, 1'b1, 1'b0, 1'b0);
        a = t + 1;
        exp_trig(a, 0, 10, 200, 0);
        k = a + 5; pulse_at(k, 4'b0001, 1'b0, 1'b0, 1'b0);
        a = k + 2;
        exp_trig(a, 1, 20, 200, 1);
        k = a + 100; pulse_at(k, 4'b0010, 1'b0, 1'b0, 1'b0);
        a = k + 2;
        exp_trig(a, 2, 30, 200, 2);
        k = a + 5; pulse_at(k, 4'b0100, 1'b0, 1'b0, 1'b0);
        a = k + 2;
        exp_trig(a, 3, 40, 200, 3);
        k = a + 5;
        exp_ev(EV_IDLE, k + 1);
        pulse_at(k, 4'b1000, 1'b0, 1'b0, 1'b0);

        // Async reset mid-ARM, between clock edges
        t = cyc + 4;
        exp_ev(EV_START, t);
        pulse_at(t, '0, 1'b1, 1'b0, 1'b0);
        a = t + 1;
        exp_trig(a, 0, 10, 200, 0);
        wait_to(a + 3);
        #2;
        mon_en = 1'b0;
        I_RST = 1'b1;
        #1;
        chk("arst_trig", 64'(O_TRIG), 0);
        chk("arst_bus", 64'({O_DLY, O_LMT}), 0);
        chk("arst_misc", 64'({O_FLG, O_OE, O_STAGE, O_BUSY, O_FAULT}), 0);
        tick();
        tick();
        I_RST = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        // Cleared table: every stage disabled, 2 cycles each, no trigger
        t = cyc + 3;
        exp_ev(EV_START, t);
        pulse_at(t, '0, 1'b1, 1'b0, 1'b0);
        exp_ev(EV_IDLE, t + 2 * N);

        wait_to(t + 2 * N + 20);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d pending, first %s expected at cyc %0d",
                     expq.size(), expq[0].kind.name(), expq[0].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
